// File: rtl/serial_mul_driver.sv
// Operand serializer and product collector for the bit-serial multiplier.
// Streams operands LSB-first, accumulates 2-bit product digits, then flushes multiplier state.
module serial_mul_driver #(
    parameter int DATA_WIDTH   = 8,
    parameter int PROD_WIDTH   = 2 * DATA_WIDTH,
    parameter int MUL_LATENCY  = 0,
    parameter int FLUSH_CYCLES = DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    output logic                  o_mul_valid,
    output logic                  o_mul_a,
    output logic                  o_mul_b,
    input  logic [1:0]            i_mul_product,
    output logic                  o_done,
    output logic [PROD_WIDTH-1:0] o_result
);

    localparam int S    = PROD_WIDTH + MUL_LATENCY;
    localparam int CMAX = (S > FLUSH_CYCLES) ? S : FLUSH_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cnt, cnt_nx;
    logic [DATA_WIDTH-1:0] sh_a, sh_a_nx, sh_b, sh_b_nx;
    logic [PROD_WIDTH-1:0] acc, acc_nx, result_nx, acc_sum;
    logic                  done_nx, mul_valid_nx, mul_a_nx, mul_b_nx;
    logic                  last_stream, last_flush, digit_en;
    logic [CW-1:0]         digit_k;

    // Digits above the result width fall off the top: accumulation is modulo 2^PROD_WIDTH.
    function automatic logic [PROD_WIDTH-1:0] acc_digit(
        input logic [PROD_WIDTH-1:0] acc_in,
        input logic [1:0]            digit,
        input logic [CW-1:0]         k
    );
        logic [PROD_WIDTH-1:0] ext;
        ext = {{(PROD_WIDTH-2){1'b0}}, digit};
        return acc_in + (ext << k);
    endfunction

    assign last_stream = (cnt == CW'(S - 1));
    assign last_flush  = (cnt == CW'(FLUSH_CYCLES - 1));
    assign digit_en    = (int'({1'b0, cnt}) >= MUL_LATENCY);
    assign digit_k     = cnt - CW'(MUL_LATENCY);
    assign acc_sum     = digit_en ? acc_digit(acc, i_mul_product, digit_k) : acc;
    assign o_ready     = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state       <= IDLE;
            cnt         <= '0;
            sh_a        <= '0;
            sh_b        <= '0;
            acc         <= '0;
            o_result    <= '0;
            o_done      <= 1'b0;
            o_mul_valid <= 1'b0;
            o_mul_a     <= 1'b0;
            o_mul_b     <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            sh_a        <= sh_a_nx;
            sh_b        <= sh_b_nx;
            acc         <= acc_nx;
            o_result    <= result_nx;
            o_done      <= done_nx;
            o_mul_valid <= mul_valid_nx;
            o_mul_a     <= mul_a_nx;
            o_mul_b     <= mul_b_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    state_nx = STREAM;
                    cnt_nx   = '0;
                end
            end
            STREAM: begin
                if (last_stream) begin
                    state_nx = FLUSH;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            FLUSH: begin
                if (last_flush) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Outputs are computed one cycle ahead so every o_mul_* comes straight from a flop.
    always_comb begin
        sh_a_nx      = sh_a;
        sh_b_nx      = sh_b;
        acc_nx       = acc;
        result_nx    = o_result;
        done_nx      = 1'b0;
        mul_valid_nx = 1'b0;
        mul_a_nx     = 1'b0;
        mul_b_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    sh_a_nx      = i_op_a >> 1;
                    sh_b_nx      = i_op_b >> 1;
                    mul_a_nx     = i_op_a[0];
                    mul_b_nx     = i_op_b[0];
                    mul_valid_nx = 1'b1;
                    acc_nx       = '0;
                end
            end
            STREAM: begin
                mul_valid_nx = 1'b1;
                acc_nx       = acc_sum;
                if (last_stream) begin
                    result_nx = acc_sum;
                    done_nx   = 1'b1;
                end else begin
                    mul_a_nx = sh_a[0];
                    mul_b_nx = sh_b[0];
                    sh_a_nx  = sh_a >> 1;
                    sh_b_nx  = sh_b >> 1;
                end
            end
            FLUSH: begin
                mul_valid_nx = !last_flush;
            end
            default: begin
                mul_valid_nx = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_mul_driver.sv
// Self-checking bench for serial_mul_driver with a causal behavioural multiplier stub
// that emits redundant 2-bit digits whose weighted sum equals the product modulo 2^16.
module tb_serial_mul_driver;

    localparam int DW    = 8;
    localparam int PW    = 16;
    localparam int S     = 16;
    localparam int F     = 8;
    localparam logic [31:0] PMASK = 32'h0000_FFFF;

    logic          clk = 1'b0;
    logic          arstn;
    logic          valid;
    logic          ready;
    logic [DW-1:0] op_a, op_b;
    logic          mul_valid, mul_a, mul_b;
    logic [1:0]    mul_product;
    logic          done;
    logic [PW-1:0] result;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] m_a, m_b, m_e;

    serial_mul_driver dut (
        .i_clk        (clk),
        .i_arstn      (arstn),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_op_a       (op_a),
        .i_op_b       (op_b),
        .o_mul_valid  (mul_valid),
        .o_mul_a      (mul_a),
        .o_mul_b      (mul_b),
        .i_mul_product(mul_product),
        .o_done       (done),
        .o_result     (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Digit k is chosen from the bits seen so far so that the running sum matches the product
    // in bits 0..k; bit 1 of each digit is random, exercising carries and the top-bit discard.
    task automatic drive_digit(input int k);
        logic [31:0] p, r;
        logic [1:0]  d;
        if (k < DW) begin
            m_a = m_a | (32'(mul_a) << k);
            m_b = m_b | (32'(mul_b) << k);
        end
        p = (m_a * m_b) & PMASK;
        r = (p - m_e) & PMASK;
        d[0] = r[k];
        d[1] = 1'($urandom_range(0, 1));
        m_e = (m_e + (32'(d) << k)) & PMASK;
        mul_product = d;
    endtask

    task automatic do_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold,
                         input int glitch_t, output int waited);
        logic [31:0] expv;
        expv   = 32'(a) * 32'(b);
        op_a   = a;
        op_b   = b;
        valid  = 1'b1;
        waited = 0;
        while (!ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ready) begin
            chk("accept_timeout", 32'(ready), 32'd1);
            valid = 1'b0;
            return;
        end
        m_a = 0;
        m_b = 0;
        m_e = 0;
        for (int t = 1; t <= S + F + 1; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) valid = hold;
            if (t == glitch_t) begin
                valid = 1'b1;
                op_a  = 8'd7;
                op_b  = 8'd7;
            end else if (t == glitch_t + 1) begin
                valid = hold;
                op_a  = a;
                op_b  = b;
            end
            if (t <= S + F) begin
                chk($sformatf("ready@%0d", t), 32'(ready), 32'd0);
                chk($sformatf("mul_valid@%0d", t), 32'(mul_valid), 32'd1);
                chk($sformatf("mul_a@%0d", t), 32'(mul_a), (t <= DW) ? 32'(a[t-1]) : 32'd0);
                chk($sformatf("mul_b@%0d", t), 32'(mul_b), (t <= DW) ? 32'(b[t-1]) : 32'd0);
                chk($sformatf("done@%0d", t), 32'(done), (t == S + 1) ? 32'd1 : 32'd0);
            end else begin
                chk("ready_end", 32'(ready), 32'd1);
                chk("mul_valid_end", 32'(mul_valid), 32'd0);
                chk("mul_a_end", 32'(mul_a), 32'd0);
                chk("done_end", 32'(done), 32'd0);
            end
            if (t == S + 1) chk($sformatf("result %0dx%0d", a, b), 32'(result), expv);
            if (t == S + F + 1) chk("result_held", 32'(result), expv);
            if (t <= S) drive_digit(t - 1);
            else mul_product = 2'($urandom_range(0, 3));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
        $fatal(1);
    end

    initial begin
        int w;
        arstn       = 1'b0;
        valid       = 1'b0;
        op_a        = '0;
        op_b        = '0;
        mul_product = '0;
        #3;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_mul_valid", 32'(mul_valid), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_b", 32'(mul_b), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;

        do_op(8'd3, 8'd5, 1'b0, -5, w);
        do_op(8'd255, 8'd255, 1'b0, -5, w);
        do_op(8'd0, 8'hA7, 1'b0, -5, w);
        do_op(8'hA7, 8'd0, 1'b0, -5, w);

        do_op(8'd12, 8'd13, 1'b1, -5, w);
        do_op(8'd200, 8'd100, 1'b0, -5, w);
        chk("b2b_wait", 32'(w), 32'd0);

        do_op(8'd9, 8'd9, 1'b0, 5, w);

        // Abort an operation in cycle 8 of STREAM with an asynchronous reset.
        op_a  = 8'hB5;
        op_b  = 8'h3C;
        valid = 1'b1;
        m_a = 0;
        m_b = 0;
        m_e = 0;
        for (int t = 1; t <= 8; t++) begin
            @(posedge clk);
            #1;
            if (t == 1) valid = 1'b0;
            drive_digit(t - 1);
        end
        #2;
        arstn = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_mul_valid", 32'(mul_valid), 32'd0);
        chk("abort_mul_a", 32'(mul_a), 32'd0);
        chk("abort_mul_b", 32'(mul_b), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
        do_op(8'd6, 8'd7, 1'b0, -5, w);

        for (int i = 0; i < 6; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0, -5, w);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
